// File: rtl/alu_pkg.sv
// Shared definitions for the ALU input sequencer: op codes, FSM states and
// helpers that encode which load strobe the control unit should raise next.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Strobe vectors are ordered {load_a, load_q, load_m}.
    localparam logic [2:0] STB_NONE = 3'b000;
    localparam logic [2:0] STB_A    = 3'b100;
    localparam logic [2:0] STB_Q    = 3'b010;
    localparam logic [2:0] STB_M    = 3'b001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        ABORT = 3'd4
    } seq_state_e;

    function automatic logic [2:0] first_strobe(input logic [1:0] op);
        logic [2:0] stb;
        if (op == OP_MUL) begin
            stb = STB_Q;
        end else begin
            stb = STB_A;
        end
        return stb;
    endfunction

    // Only div has two strobes in LOAD: Q first, then M.
    function automatic logic [2:0] load_strobe(input logic [1:0] op, input logic step);
        logic [2:0] stb;
        if ((op == OP_DIV) && (step == 1'b0)) begin
            stb = STB_Q;
        end else begin
            stb = STB_M;
        end
        return stb;
    endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// Up-counter with synchronous clear and enable; expired flags the cycle in
// which the next increment would reach LIMIT.
module cycle_watchdog #(
    parameter int LIMIT = 255,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset_input,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, saturate at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable && (count_q != LIMIT_V)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable & ~clear & (count_q == LAST);

endmodule

// File: rtl/alu_input_sequencer.sv
// Feeds one buffered operation at a time into the ALU control unit, placing
// each operand on INBUS in the cycle of its load strobe and policing order.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_input,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_q,
    input  logic [WIDTH-1:0] req_m,
    output logic             cu_begin,
    output logic [1:0]       cu_op_code,
    output logic [WIDTH-1:0] inbus,
    input  logic             load_a,
    input  logic             load_q,
    input  logic             load_m,
    input  logic             cu_end,
    output logic             busy,
    output logic             op_done,
    output logic             seq_error,
    output logic             div_zero,
    output logic             timeout,
    output logic             cu_reset_req
);

    seq_state_e       state_q, state_d;

    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_op_q, pend_op_d;
    logic [WIDTH-1:0] pend_a_q, pend_a_d;
    logic [WIDTH-1:0] pend_qr_q, pend_qr_d;
    logic [WIDTH-1:0] pend_m_q, pend_m_d;

    logic [1:0]       act_op_q, act_op_d;
    logic [WIDTH-1:0] act_a_q, act_a_d;
    logic [WIDTH-1:0] act_qr_q, act_qr_d;
    logic [WIDTH-1:0] act_m_q, act_m_d;

    logic             load_step_q, load_step_d;
    logic             abort_timeout_q, abort_timeout_d;

    logic [2:0]       strobes_s;
    logic             accept_s;
    logic             slot_release_s;
    logic             wd_clear_s;
    logic             wd_enable_s;
    logic             wd_expired_s;
    logic             cu_begin_s;
    logic             op_done_s;
    logic             seq_error_s;
    logic             div_zero_s;
    logic             timeout_s;
    logic             cu_reset_req_s;

    assign strobes_s = {load_a, load_q, load_m};
    assign accept_s  = req_valid & ~pend_valid_q;

    cycle_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset_input (reset_input),
        .clear       (wd_clear_s),
        .enable      (wd_enable_s),
        .expired     (wd_expired_s)
    );

    // Sequencing FSM: launch, strobe-order checking, watchdog and abort.
    always_comb begin
        state_d         = state_q;
        act_op_d        = act_op_q;
        act_a_d         = act_a_q;
        act_qr_d        = act_qr_q;
        act_m_d         = act_m_q;
        load_step_d     = load_step_q;
        abort_timeout_d = abort_timeout_q;
        slot_release_s  = 1'b0;
        wd_clear_s      = 1'b0;
        wd_enable_s     = 1'b0;
        cu_begin_s      = 1'b0;
        op_done_s       = 1'b0;
        seq_error_s     = 1'b0;
        div_zero_s      = 1'b0;
        timeout_s       = 1'b0;
        cu_reset_req_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!pend_valid_q) begin
                    state_d = IDLE;
                end else if ((pend_op_q == OP_DIV) && (pend_m_q == {WIDTH{1'b0}})) begin
                    div_zero_s     = 1'b1;
                    slot_release_s = 1'b1;
                end else begin
                    act_op_d       = pend_op_q;
                    act_a_d        = pend_a_q;
                    act_qr_d       = pend_qr_q;
                    act_m_d        = pend_m_q;
                    slot_release_s = 1'b1;
                    state_d        = START;
                end
            end
            START: begin
                cu_begin_s  = 1'b1;
                load_step_d = 1'b0;
                if (strobes_s == first_strobe(act_op_q)) begin
                    state_d = LOAD;
                end else begin
                    abort_timeout_d = 1'b0;
                    state_d         = ABORT;
                end
            end
            LOAD: begin
                if (strobes_s != load_strobe(act_op_q, load_step_q)) begin
                    abort_timeout_d = 1'b0;
                    state_d         = ABORT;
                end else if (strobes_s == STB_M) begin
                    wd_clear_s = 1'b1;
                    state_d    = RUN;
                end else begin
                    load_step_d = 1'b1;
                end
            end
            RUN: begin
                wd_enable_s = 1'b1;
                if (cu_end) begin
                    op_done_s = 1'b1;
                    state_d   = IDLE;
                end else if (wd_expired_s) begin
                    abort_timeout_d = 1'b1;
                    state_d         = ABORT;
                end else begin
                    state_d = RUN;
                end
            end
            ABORT: begin
                cu_reset_req_s = 1'b1;
                if (abort_timeout_q) begin
                    timeout_s = 1'b1;
                end else begin
                    seq_error_s = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending slot: operands the op ignores are stored as zero.
    always_comb begin
        pend_op_d = pend_op_q;
        pend_a_d  = pend_a_q;
        pend_qr_d = pend_qr_q;
        pend_m_d  = pend_m_q;
        if (accept_s) begin
            pend_valid_d = 1'b1;
            pend_op_d    = req_op;
            pend_a_d     = (req_op == OP_MUL) ? {WIDTH{1'b0}} : req_a;
            pend_qr_d    = ((req_op == OP_ADD) || (req_op == OP_SUB)) ? {WIDTH{1'b0}} : req_q;
            pend_m_d     = req_m;
        end else if (slot_release_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // State, pending and active registers.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            state_q         <= IDLE;
            pend_valid_q    <= 1'b0;
            pend_op_q       <= 2'b00;
            pend_a_q        <= {WIDTH{1'b0}};
            pend_qr_q       <= {WIDTH{1'b0}};
            pend_m_q        <= {WIDTH{1'b0}};
            act_op_q        <= 2'b00;
            act_a_q         <= {WIDTH{1'b0}};
            act_qr_q        <= {WIDTH{1'b0}};
            act_m_q         <= {WIDTH{1'b0}};
            load_step_q     <= 1'b0;
            abort_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_valid_q    <= pend_valid_d;
            pend_op_q       <= pend_op_d;
            pend_a_q        <= pend_a_d;
            pend_qr_q       <= pend_qr_d;
            pend_m_q        <= pend_m_d;
            act_op_q        <= act_op_d;
            act_a_q         <= act_a_d;
            act_qr_q        <= act_qr_d;
            act_m_q         <= act_m_d;
            load_step_q     <= load_step_d;
            abort_timeout_q <= abort_timeout_d;
        end
    end

    // INBUS follows the strobes in the same cycle; A has priority, then Q.
    always_comb begin
        if (load_a) begin
            inbus = act_a_q;
        end else if (load_q) begin
            inbus = act_qr_q;
        end else if (load_m) begin
            inbus = act_m_q;
        end else begin
            inbus = {WIDTH{1'b0}};
        end
    end

    assign req_ready    = ~pend_valid_q;
    assign busy         = (state_q != IDLE);
    assign cu_op_code   = act_op_q;
    assign cu_begin     = cu_begin_s;
    assign op_done      = op_done_s;
    assign seq_error    = seq_error_s;
    assign div_zero     = div_zero_s;
    assign timeout      = timeout_s;
    assign cu_reset_req = cu_reset_req_s;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer; the bench itself plays the control unit.
module tb_alu_input_sequencer;

    logic       clk = 1'b0;
    logic       reset_input = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_a = 8'h00, req_q = 8'h00, req_m = 8'h00;
    logic       cu_begin;
    logic [1:0] cu_op_code;
    logic [7:0] inbus;
    logic       load_a = 1'b0, load_q = 1'b0, load_m = 1'b0, cu_end = 1'b0;
    logic       busy, op_done, seq_error, div_zero, timeout, cu_reset_req;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [17:0] RESET_VEC = {1'b1, 7'b0000000, 2'b00, 8'h00};

    alu_input_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset_input(reset_input),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_q(req_q), .req_m(req_m),
        .cu_begin(cu_begin), .cu_op_code(cu_op_code), .inbus(inbus),
        .load_a(load_a), .load_q(load_q), .load_m(load_m), .cu_end(cu_end),
        .busy(busy), .op_done(op_done), .seq_error(seq_error), .div_zero(div_zero),
        .timeout(timeout), .cu_reset_req(cu_reset_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q, input logic [7:0] m);
        req_valid = 1'b1; req_op = op; req_a = a; req_q = q; req_m = m;
    endtask

    function automatic logic [17:0] out_vec();
        return {req_ready, busy, cu_begin, op_done, seq_error, div_zero, timeout, cu_reset_req, cu_op_code, inbus};
    endfunction

    task automatic test_reset();
        reset_input = 1'b1;
        tick(); tick();
        reset_input = 1'b0;
        #2;
        n_checks++;
        if (out_vec() !== RESET_VEC) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RESET_VEC); end
    endtask

    task automatic test_add();
        tick(); issue(2'b00, 8'h12, 8'h33, 8'h05); #2;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", req_ready); end
        tick(); req_valid = 1'b0; #2;
        n_checks++;
        if ({req_ready, busy, cu_begin} !== 3'b000) begin n_fail++; $display("FAIL add_pending: got %b want 000", {req_ready, busy, cu_begin}); end
        tick(); load_a = 1'b1; #2;
        n_checks++;
        if ({cu_begin, busy, cu_op_code, inbus} !== {1'b1, 1'b1, 2'b00, 8'h12}) begin
            n_fail++; $display("FAIL add_begin: got %b %b %b %h want 1 1 00 12", cu_begin, busy, cu_op_code, inbus); end
        tick(); load_a = 1'b0; load_m = 1'b1; #2;
        n_checks++;
        if ({cu_begin, inbus} !== {1'b0, 8'h05}) begin n_fail++; $display("FAIL add_inbus_m: got %b %h want 0 05", cu_begin, inbus); end
        tick(); load_m = 1'b0; #2;
        tick(); #2;
        n_checks++;
        if ({op_done, busy, inbus} !== {1'b0, 1'b1, 8'h00}) begin n_fail++; $display("FAIL add_run: got %b %b %h want 0 1 00", op_done, busy, inbus); end
        tick(); cu_end = 1'b1; #2;
        n_checks++;
        if (op_done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", op_done); end
        tick(); cu_end = 1'b0; #2;
        n_checks++;
        if ({op_done, busy} !== 2'b00) begin n_fail++; $display("FAIL add_idle: got %b want 00", {op_done, busy}); end
    endtask

    task automatic test_div();
        tick(); issue(2'b11, 8'h00, 8'h64, 8'h07);
        tick(); req_valid = 1'b0;
        tick(); load_a = 1'b1; #2;
        n_checks++;
        if ({cu_begin, cu_op_code, inbus} !== {1'b1, 2'b11, 8'h00}) begin
            n_fail++; $display("FAIL div_a: got %b %b %h want 1 11 00", cu_begin, cu_op_code, inbus); end
        tick(); load_a = 1'b0; load_q = 1'b1; #2;
        n_checks++;
        if ({cu_op_code, inbus} !== {2'b11, 8'h64}) begin n_fail++; $display("FAIL div_q: got %b %h want 11 64", cu_op_code, inbus); end
        tick(); load_q = 1'b0; load_m = 1'b1; #2;
        n_checks++;
        if ({cu_op_code, inbus, seq_error} !== {2'b11, 8'h07, 1'b0}) begin
            n_fail++; $display("FAIL div_m: got %b %h %b want 11 07 0", cu_op_code, inbus, seq_error); end
        tick(); load_m = 1'b0; cu_end = 1'b1; #2;
        n_checks++;
        if ({op_done, cu_op_code} !== {1'b1, 2'b11}) begin n_fail++; $display("FAIL div_done: got %b %b want 1 11", op_done, cu_op_code); end
        tick(); cu_end = 1'b0; #2;
    endtask

    task automatic test_div_zero();
        tick(); issue(2'b11, 8'h09, 8'h40, 8'h00);
        tick(); req_valid = 1'b0; #2;
        n_checks++;
        if ({div_zero, cu_begin, req_ready} !== 3'b100) begin n_fail++; $display("FAIL dz_pulse: got %b want 100", {div_zero, cu_begin, req_ready}); end
        tick(); #2;
        n_checks++;
        if ({div_zero, cu_begin, req_ready, busy} !== 4'b0010) begin
            n_fail++; $display("FAIL dz_after: got %b want 0010", {div_zero, cu_begin, req_ready, busy}); end
    endtask

    task automatic test_back_to_back();
        tick(); issue(2'b10, 8'h55, 8'h0A, 8'h03);
        tick(); req_valid = 1'b0;
        tick(); load_q = 1'b1; issue(2'b01, 8'h20, 8'h77, 8'h08); #2;
        n_checks++;
        if ({cu_begin, cu_op_code, inbus, req_ready} !== {1'b1, 2'b10, 8'h0A, 1'b1}) begin
            n_fail++; $display("FAIL b2b_first: got %b %b %h %b want 1 10 0a 1", cu_begin, cu_op_code, inbus, req_ready); end
        tick(); req_valid = 1'b0; load_q = 1'b0; load_m = 1'b1; #2;
        n_checks++;
        if ({inbus, req_ready} !== {8'h03, 1'b0}) begin n_fail++; $display("FAIL b2b_m: got %h %b want 03 0", inbus, req_ready); end
        tick(); load_m = 1'b0;
        tick(); cu_end = 1'b1; #2;
        n_checks++;
        if ({op_done, req_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_done: got %b want 10", {op_done, req_ready}); end
        tick(); cu_end = 1'b0; #2;
        n_checks++;
        if ({cu_begin, req_ready, busy} !== 3'b000) begin n_fail++; $display("FAIL b2b_gap: got %b want 000", {cu_begin, req_ready, busy}); end
        tick(); load_a = 1'b1; #2;
        n_checks++;
        if ({cu_begin, req_ready, cu_op_code, inbus} !== {1'b1, 1'b1, 2'b01, 8'h20}) begin
            n_fail++; $display("FAIL b2b_second: got %b %b %b %h want 1 1 01 20", cu_begin, req_ready, cu_op_code, inbus); end
        tick(); load_a = 1'b0; load_m = 1'b1; #2;
        n_checks++;
        if (inbus !== 8'h08) begin n_fail++; $display("FAIL b2b_second_m: got %h want 08", inbus); end
        tick(); load_m = 1'b0; cu_end = 1'b1; #2;
        n_checks++;
        if (op_done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", op_done); end
        tick(); cu_end = 1'b0;
    endtask

    task automatic test_seq_error();
        tick(); issue(2'b00, 8'h11, 8'h00, 8'h22);
        tick(); req_valid = 1'b0;
        tick(); load_m = 1'b1; #2;
        n_checks++;
        if ({cu_begin, seq_error, cu_reset_req} !== 3'b100) begin
            n_fail++; $display("FAIL err_start: got %b want 100", {cu_begin, seq_error, cu_reset_req}); end
        tick(); load_m = 1'b0; #2;
        n_checks++;
        if ({seq_error, cu_reset_req, timeout, busy} !== 4'b1101) begin
            n_fail++; $display("FAIL err_abort: got %b want 1101", {seq_error, cu_reset_req, timeout, busy}); end
        tick(); #2;
        n_checks++;
        if ({seq_error, cu_reset_req, busy, cu_begin} !== 4'b0000) begin
            n_fail++; $display("FAIL err_idle: got %b want 0000", {seq_error, cu_reset_req, busy, cu_begin}); end
    endtask

    // Launch an add and walk it to the first RUN cycle boundary.
    task automatic launch_add();
        tick(); issue(2'b00, 8'h01, 8'h00, 8'h02);
        tick(); req_valid = 1'b0;
        tick(); load_a = 1'b1;
        tick(); load_a = 1'b0; load_m = 1'b1;
        tick(); load_m = 1'b0;
    endtask

    task automatic test_timeout();
        int  seen_at;
        bit  stray;
        seen_at = 0;
        stray   = 1'b0;
        launch_add();
        #2;
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) begin tick(); end
            load_a = (i == 10);
            #2;
            if (seq_error || op_done) stray = 1'b1;
            if (timeout) begin
                seen_at = i;
                if (cu_reset_req !== 1'b1) stray = 1'b1;
                break;
            end
        end
        load_a = 1'b0;
        n_checks++;
        if (seen_at !== 256) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 256", seen_at); end
        n_checks++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL timeout_side: got %b want 0", stray); end
        tick(); #2;
        n_checks++;
        if ({busy, timeout} !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got %b want 00", {busy, timeout}); end
    endtask

    task automatic test_end_beats_timeout();
        bit done_seen;
        done_seen = 1'b0;
        launch_add();
        #2;
        for (int i = 1; i <= 255; i++) begin
            if (i > 1) begin tick(); end
            cu_end = (i == 255);
            #2;
            if (i == 255) done_seen = op_done;
        end
        tick(); cu_end = 1'b0; #2;
        n_checks++;
        if ({done_seen, timeout, cu_reset_req, busy} !== 4'b1000) begin
            n_fail++; $display("FAIL end_wins: got %b want 1000", {done_seen, timeout, cu_reset_req, busy}); end
    endtask

    task automatic test_reset_mid_run();
        bit stray;
        stray = 1'b0;
        tick(); issue(2'b10, 8'h00, 8'h3C, 8'h04);
        tick(); req_valid = 1'b0;
        tick(); load_q = 1'b1; issue(2'b00, 8'h05, 8'h00, 8'h06);
        tick(); req_valid = 1'b0; load_q = 1'b0; load_m = 1'b1;
        tick(); load_m = 1'b0;
        tick();
        tick(); reset_input = 1'b1;
        tick(); reset_input = 1'b0; #2;
        n_checks++;
        if (out_vec() !== RESET_VEC) begin n_fail++; $display("FAIL reset_mid_run: got %h want %h", out_vec(), RESET_VEC); end
        for (int i = 0; i < 4; i++) begin
            tick(); #2;
            if (cu_begin || cu_reset_req || busy) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_seq_error();
        test_timeout();
        test_end_beats_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
